// File: rtl/nar_pkg.sv
// Shared defaults and FSM encoding for the tap delay line.
// Imported by the delay-line top and its pointer counter.
package nar_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_TAPS = 17;
  localparam int DEF_PTR_W    = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/tap_ptr_counter.sv
// Wrapping 0..N-1 pointer with load, enable and up/down select.
// Used for both the write head and the tap read pointer.
module tap_ptr_counter
  import nar_pkg::*;
#(
  parameter int N = DEF_NUM_TAPS,
  parameter int W = DEF_PTR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] TOP = W'(N - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      if (up) begin
        cnt <= (cnt == TOP) ? '0 : cnt + 1'b1;
      end else begin
        cnt <= (cnt == '0) ? TOP : cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/tap_delay_line.sv
// Circular sample history that replays x[n-k], k=0..NUM_TAPS-1,
// to a MAC stage once per accepted input sample.
module tap_delay_line
  import nar_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int PTR_W    = DEF_PTR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tap_valid,
  input  logic              tap_ready,
  output logic [DATA_W-1:0] tap_data,
  output logic [PTR_W-1:0]  tap_idx,
  output logic              tap_last,
  output logic              primed
);

  localparam logic [PTR_W-1:0] K_LAST = PTR_W'(NUM_TAPS - 1);
  localparam logic [PTR_W:0]   FILL_MAX = (PTR_W + 1)'(NUM_TAPS);

  state_e            state_q;
  state_e            state_d;
  logic [DATA_W-1:0] mem [NUM_TAPS];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  k_q;
  logic [PTR_W:0]    fill_q;
  logic              accept;
  logic              tap_hs;
  logic              is_last;
  logic              step;

  assign accept  = (state_q == IDLE) && in_valid && !flush;
  assign tap_hs  = (state_q == STREAM) && tap_ready && !flush;
  assign is_last = (k_q == K_LAST);
  assign step    = tap_hs && !is_last;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = STREAM;
      STREAM:  if (tap_ready && is_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  tap_ptr_counter #(
    .N(NUM_TAPS),
    .W(PTR_W)
  ) u_head (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .en      (accept),
    .up      (1'b1),
    .load    (1'b0),
    .load_val('0),
    .cnt     (head)
  );

  // Reads start at the slot just written and walk backwards in time.
  tap_ptr_counter #(
    .N(NUM_TAPS),
    .W(PTR_W)
  ) u_rd_ptr (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .en      (step),
    .up      (1'b0),
    .load    (accept),
    .load_val(head),
    .cnt     (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      k_q <= '0;
    end else if (accept) begin
      k_q <= '0;
    end else if (tap_hs) begin
      k_q <= is_last ? '0 : k_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      fill_q <= '0;
    end else if (accept && (fill_q != FILL_MAX)) begin
      fill_q <= fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        mem[i] <= '0;
      end
    end else if (accept) begin
      mem[head] <= in_data;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign tap_valid = (state_q == STREAM);
  assign tap_data  = tap_valid ? mem[rd_ptr] : '0;
  assign tap_idx   = k_q;
  assign tap_last  = tap_valid && is_last;
  assign primed    = (fill_q == FILL_MAX);

endmodule

// File: tb/tb_tap_delay_line.sv
// Bench for tap_delay_line: directed frames plus random traffic
// compared every cycle against a sample-history model.
module tb_tap_delay_line;

  localparam int DW = 16;
  localparam int NT = 17;
  localparam int PW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          tap_ready = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          tap_valid;
  logic          tap_last;
  logic          primed;
  logic [DW-1:0] tap_data;
  logic [PW-1:0] tap_idx;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  tap_delay_line #(
    .DATA_W  (DW),
    .NUM_TAPS(NT),
    .PTR_W   (PW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .tap_valid(tap_valid),
    .tap_ready(tap_ready),
    .tap_data (tap_data),
    .tap_idx  (tap_idx),
    .tap_last (tap_last),
    .primed   (primed)
  );

  // Model: newest-first list of samples since clear, frame position.
  int unsigned hist[$];
  bit          m_stream = 1'b0;
  int          m_k = 0;
  int          m_fill = 0;

  always @(posedge clk) begin
    if (rst || flush) begin
      hist.delete();
      m_stream = 1'b0;
      m_k = 0;
      m_fill = 0;
    end else if (!m_stream) begin
      if (in_valid) begin
        hist.push_front(int'(in_data));
        if (hist.size() > NT) void'(hist.pop_back());
        if (m_fill < NT) m_fill++;
        m_stream = 1'b1;
        m_k = 0;
      end
    end else if (tap_ready) begin
      if (m_k == NT - 1) begin
        m_stream = 1'b0;
        m_k = 0;
      end else begin
        m_k++;
      end
    end
  end

  function automatic int exp_data();
    if (m_stream && m_k < hist.size()) return int'(hist[m_k]);
    return 0;
  endfunction

  task automatic chk(input string name, input longint act,
                     input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_in_ready", longint'(in_ready), longint'(!m_stream));
      chk("m_tap_valid", longint'(tap_valid), longint'(m_stream));
      chk("m_tap_data", longint'(tap_data), longint'(exp_data()));
      chk("m_tap_idx", longint'(tap_idx), longint'(m_k));
      chk("m_tap_last", longint'(tap_last),
          longint'(m_stream && m_k == NT - 1));
      chk("m_primed", longint'(primed), longint'(m_fill == NT));
    end
  end

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input int v);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("push_timeout", 0, 1);
    in_valid = 1'b1;
    in_data = DW'(v);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idx(input int k);
    int n = 0;
    while (!(tap_valid && int'(tap_idx) == k) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("wait_idx_timeout", n, k);
  endtask

  task automatic check_frame(input string name, input int newest,
                             input int cnt);
    for (int i = 0; i < NT; i++) begin
      chk({name, "_data"}, longint'(tap_data),
          (i < cnt) ? longint'(newest - i) : 0);
      chk({name, "_idx"}, longint'(tap_idx), longint'(i));
      chk({name, "_last"}, longint'(tap_last), longint'(i == NT - 1));
      chk({name, "_rdy"}, longint'(in_ready), 0);
      @(negedge clk);
    end
    chk({name, "_rdy_after"}, longint'(in_ready), 1);
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_in_ready"}, longint'(in_ready), 1);
    chk({name, "_tap_valid"}, longint'(tap_valid), 0);
    chk({name, "_tap_data"}, longint'(tap_data), 0);
    chk({name, "_tap_idx"}, longint'(tap_idx), 0);
    chk({name, "_tap_last"}, longint'(tap_last), 0);
    chk({name, "_primed"}, longint'(primed), 0);
  endtask

  logic [DW-1:0] held;

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    chk_reset("rst0");
    rst = 1'b0;

    push(5);
    check_frame("single", 5, 1);

    pulse_rst();
    for (int v = 1; v <= 17; v++) begin
      push(v);
      if (v == 16) chk("primed_16", longint'(primed), 0);
    end
    chk("primed_17", longint'(primed), 1);
    push(18);
    chk("model_pin18", longint'(exp_data()), 18);
    check_frame("hist18", 18, 17);

    pulse_rst();
    for (int v = 1; v <= 20; v++) push(v);
    chk("model_pin20", longint'(exp_data()), 20);
    check_frame("wrap20", 20, 17);

    push(16'h30);
    wait_idx(5);
    held = tap_data;
    chk("stall_val", longint'(held), 16);
    tap_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_idx", longint'(tap_idx), 5);
      chk("stall_data", longint'(tap_data), 16);
    end
    tap_ready = 1'b1;
    @(negedge clk);
    chk("resume_idx", longint'(tap_idx), 6);
    chk("resume_data", longint'(tap_data), 15);

    push(16'h40);
    wait_idx(9);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_valid", longint'(tap_valid), 0);
    chk("flush_primed", longint'(primed), 0);
    chk("flush_ready", longint'(in_ready), 1);
    push(16'hAA);
    check_frame("post_flush", 16'hAA, 1);

    push(16'h11);
    wait_idx(7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("rst_mid");

    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = DW'($urandom);
      tap_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 150) == 0);
      rst = ($urandom_range(0, 400) == 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    flush = 1'b0;
    rst = 1'b0;
    tap_ready = 1'b1;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tap_delay_line.md
TAP_DELAY_LINE -- requirements
Module: tap_delay_line

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, sample width in bits.
REQ-002 The block SHALL have parameter NUM_TAPS, default 17, delay-line depth; tap pointers wrap at NUM_TAPS-1.
REQ-003 The block SHALL have parameter PTR_W, default 5, pointer/index width.
REQ-004 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 The block SHALL have port flush  input  1  synchronous clear of history, same effect as rst.
REQ-007 The block SHALL have port in_valid  input  1  new sample offered.
REQ-008 The block SHALL have port in_ready  output  1  sample accepted when in_valid && in_ready.
REQ-009 The block SHALL have port in_data  input  DATA_W  sample value.
REQ-010 The block SHALL have port tap_valid  output  1  tap word presented to MAC stage.
REQ-011 The block SHALL have port tap_ready  input  1  MAC stage takes tap when tap_valid && tap_ready.
REQ-012 The block SHALL have port tap_data  output  DATA_W  delayed sample x[n-k].
REQ-013 The block SHALL have port tap_idx  output  PTR_W  k, 0 = newest.
REQ-014 The block SHALL have port tap_last  output  1  high with k = NUM_TAPS-1.
REQ-015 The block SHALL have port primed  output  1  NUM_TAPS real samples held since last rst/flush.

Function
REQ-016 Storage SHALL be NUM_TAPS x DATA_W registers, circular; head pointer = next write slot.
REQ-017 FSM SHALL have states IDLE and STREAM; in_ready = 1 only in IDLE.
REQ-018 IDLE, in_valid: SHALL write in_data to mem[head], load rd_ptr = head, k = 0, advance head (NUM_TAPS-1 -> 0), enter STREAM.
REQ-019 STREAM SHALL assert tap_valid with tap_data = mem[rd_ptr], tap_idx = k, tap_last = (k == NUM_TAPS-1); first tap valid the cycle after input acceptance.
REQ-020 On tap handshake with k < NUM_TAPS-1: rd_ptr SHALL decrement (0 -> NUM_TAPS-1), k SHALL increment.
REQ-021 On tap handshake with tap_last: SHALL return to IDLE; in_ready high next cycle (one-cycle bubble between frames).
REQ-022 tap_valid && !tap_ready: tap_data, tap_idx, tap_last SHALL hold stable; no pointer movement.
REQ-023 Tap outputs SHALL depend only on registered state; no combinational path from in_* or tap_ready.
REQ-024 Never-written slots SHALL read 0.
REQ-025 primed SHALL rise the cycle after the NUM_TAPS-th acceptance and remain high until rst/flush (fill counter saturates).
REQ-026 flush in any state SHALL take effect next edge: zero mem, head = 0, primed = 0, IDLE; in-flight frame aborted, no tap_last.
REQ-027 Priority SHALL be rst > flush > handshakes; in_valid with flush is dropped.

Reset
REQ-028 After rst: state IDLE, in_ready 1, tap_valid 0, tap_data 0, tap_idx 0, tap_last 0, primed 0, head 0, rd_ptr 0, mem all 0.

Structure
REQ-029 Package nar_pkg SHALL hold DATA_W, NUM_TAPS, PTR_W defaults and the FSM state enum.
REQ-030 Sub-module tap_ptr_counter (wrapping 0..NUM_TAPS-1 counter, en/rst, up/down select) SHALL implement head and rd_ptr.

Verification
REQ-031 rst mid-STREAM (k=7) -> next cycle all REQ-028 values, in_ready 1.
REQ-032 After rst, push 0x0005, tap_ready=1 -> 17 taps: 0x0005 at k=0, then sixteen 0x0000, tap_last only at k=16, in_ready low for 17 cycles.
REQ-033 Push 1..17 -> primed high after 17th; push 18 -> taps 18,17,...,2, k=0..16.
REQ-034 Push 20 samples (head wraps 16->0) -> frame 20 taps 20,19,...,4, no duplicate/missing values.
REQ-035 tap_ready low 3 cycles at k=5 -> tap_data/tap_idx=5 stable, then stream resumes at k=6.
REQ-036 flush at k=9 -> tap_valid 0 next cycle, primed 0; next push 0x00AA -> taps 0x00AA then sixteen 0x0000.
